// File: rtl/riscv_mc_core.sv
// rtl/riscv_mc_core.sv - multi-cycle RV32I-subset core with one unified req/ready memory port
// Optional feature macro: RV_PERF_CNT_EN (adds cycle_cnt/instret_cnt)
module riscv_mc_core #(
  parameter int              XLEN     = 32,
  parameter int              REGS     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic [XLEN-1:0] pc_out
`ifdef RV_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);
  localparam int RW = $clog2(REGS);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] EXEC_R  = 4'd2;
  localparam logic [3:0] EXEC_I  = 4'd3;
  localparam logic [3:0] ALU_WB  = 4'd4;
  localparam logic [3:0] MEM_ADR = 4'd5;
  localparam logic [3:0] MEM_RD  = 4'd6;
  localparam logic [3:0] MEM_WB  = 4'd7;
  localparam logic [3:0] MEM_WR  = 4'd8;
  localparam logic [3:0] BRANCH  = 4'd9;
  localparam logic [3:0] JAL     = 4'd10;
  localparam logic [3:0] JALR    = 4'd11;
  localparam logic [3:0] LUI     = 4'd12;
  localparam logic [3:0] HALT    = 4'd13;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_L    = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6f;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI  = 7'h37;

  logic [3:0]      state;
  logic [XLEN-1:0] pc, oldpc, a, b, aluout, mdr;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [REGS];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic sub,
                                          input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    case (f3)
      3'b000:  alu = sub ? x - y : x + y;
      3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, x < y};
      3'b100:  alu = x ^ y;
      3'b110:  alu = x | y;
      3'b111:  alu = x & y;
      default: alu = x + y;
    endcase
  endfunction

  // Legality is resolved entirely in DECODE so every illegal form halts after two cycles
  logic [3:0] dec_next;
  logic       legal, writes_rd;
  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    dec_next  = HALT;
    case (opcode)
      OP_R: begin
        legal = (funct7 == 7'h00 && funct3 inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) ||
                (funct7 == 7'h20 && funct3 == 3'd0);
        writes_rd = 1'b1;
        dec_next  = EXEC_R;
      end
      OP_I: begin
        legal     = funct3 inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        writes_rd = 1'b1;
        dec_next  = EXEC_I;
      end
      OP_L: begin
        legal     = (funct3 == 3'd2);
        writes_rd = 1'b1;
        dec_next  = MEM_ADR;
      end
      OP_S: begin
        legal    = (funct3 == 3'd2);
        dec_next = MEM_ADR;
      end
      OP_B: begin
        legal    = funct3 inside {3'd0, 3'd1, 3'd4, 3'd5};
        dec_next = BRANCH;
      end
      OP_JAL: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        dec_next  = JAL;
      end
      OP_JALR: begin
        legal     = (funct3 == 3'd0);
        writes_rd = 1'b1;
        dec_next  = JALR;
      end
      OP_LUI: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        dec_next  = LUI;
      end
      default: legal = 1'b0;
    endcase
    if (!legal || (writes_rd && ({27'b0, rd} >= REGS)))
      dec_next = HALT;
  end

  logic [XLEN-1:0] eff_addr;
  assign eff_addr = a + ((opcode == OP_S) ? imm_s : imm_i);

  logic taken;
  always_comb begin
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      default: taken = 1'b0;
    endcase
  end

  logic            rf_we;
  logic [XLEN-1:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wd = aluout;
    case (state)
      ALU_WB:      rf_we = 1'b1;
      MEM_WB:      begin rf_we = 1'b1; rf_wd = mdr; end
      JAL, JALR:   begin rf_we = 1'b1; rf_wd = oldpc + XLEN'(4); end
      LUI:         begin rf_we = 1'b1; rf_wd = imm_u; end
      default:     rf_we = 1'b0;
    endcase
    if (rd == 5'd0)
      rf_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      oldpc  <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      for (int i = 0; i < REGS; i++)
        rf[i] <= '0;
    end else begin
      if (rf_we)
        rf[rd[RW-1:0]] <= rf_wd;
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata[31:0];
          oldpc <= pc;
          pc    <= pc + XLEN'(4);
          state <= DECODE;
        end
        DECODE: begin
          a      <= rf[rs1[RW-1:0]];
          b      <= rf[rs2[RW-1:0]];
          aluout <= oldpc + ((opcode == OP_JAL) ? imm_j : imm_b);
          state  <= dec_next;
        end
        EXEC_R: begin
          aluout <= alu(funct3, funct7[5], a, b);
          state  <= ALU_WB;
        end
        EXEC_I: begin
          aluout <= alu(funct3, 1'b0, a, imm_i);
          state  <= ALU_WB;
        end
        MEM_ADR: begin
          aluout <= eff_addr;
          if (eff_addr[1:0] != 2'b00)
            state <= HALT;
          else
            state <= (opcode == OP_S) ? MEM_WR : MEM_RD;
        end
        MEM_RD: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= MEM_WB;
        end
        MEM_WR: if (mem_ready) state <= FETCH;
        BRANCH: begin
          if (taken)
            pc <= aluout;
          state <= FETCH;
        end
        JAL: begin
          pc    <= aluout;
          state <= FETCH;
        end
        JALR: begin
          pc    <= (a + imm_i) & ~XLEN'(1);
          state <= FETCH;
        end
        ALU_WB, MEM_WB, LUI: state <= FETCH;
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so an abandoned access drops immediately
  logic access;
  assign access    = rst && (state == FETCH || state == MEM_RD || state == MEM_WR);
  assign mem_req   = access;
  assign mem_we    = rst && (state == MEM_WR);
  assign mem_addr  = !access ? '0 : ((state == FETCH) ? pc : aluout);
  assign mem_wdata = mem_we ? b : '0;
  assign halted    = rst && (state == HALT);
  assign pc_out    = pc;

`ifdef RV_PERF_CNT_EN
  logic retire;
  assign retire = (state inside {ALU_WB, MEM_WB, BRANCH, JAL, JALR, LUI}) ||
                  (state == MEM_WR && mem_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire)
        instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif
endmodule
